tx_stream_arbiter: RTL and testbench
====================================

// Module: tx_stream_arbiter
// PURPOSE
//  Round-robin arbiter that shares the FT245 tx write path (core_ft245 tx_write/tx_data) between NUM_SRC producers.
//  Each grant emits one framed burst: header word, then LEN payload words, then an optional checksum trailer.
//  Sits in the tx_clk domain, between the test/data producers and core_ft245.
// PARAMETERS
//  NUM_SRC   4    number of requesters, 2..16
//  LEN_W     16   width of per-source burst length
//  GAP_CYC   1    idle cycles after each burst before the next arbitration, 1..15
// PORTS
//  clk_in     in   1            tx clock (same clock as core_ft245 tx_clk)
//  rst_in     in   1            asynchronous, active-high reset
//  src_req    in   NUM_SRC      burst request per source, level
//  src_len    in   NUM_SRC*LEN_W payload word count per source, packed, sampled at grant
//  src_valid  in   NUM_SRC      source has a payload word on src_data
//  src_data   in   NUM_SRC*32   payload word per source, packed
//  src_ack    out  NUM_SRC      pop strobe: word on src_data consumed this cycle
//  src_grant  out  NUM_SRC      one-hot, high from HEADER through the last word of the burst
//  tx_ready   in   1            downstream can take >=2 more words (not almost-full)
//  tx_write   out  1            write strobe to core_ft245, registered
//  tx_data    out  32           word to core_ft245, registered
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, tx_write=0, tx_data=0, src_grant=0, src_ack=0, busy=0, counters=0.
//  Reset asserted mid-burst aborts immediately; the partial frame is not completed.
//  FSM: IDLE -> HEADER -> BURST -> (TRAILER) -> GAP -> IDLE.
//  IDLE: g = first i with src_req[i], searching ptr, ptr+1, .. mod NUM_SRC. If one is found:
//   latch g, cnt=src_len[g], and go to HEADER. src_grant[g] rises one cycle after the request is seen.
//  HEADER: when tx_ready=1, tx_write<=1 and tx_data<={8'hA5,4'h0,g[3:0],len[15:0]}.
//   len is zero-extended if LEN_W<16 and truncated if LEN_W>16.
//   Next state is BURST if cnt!=0. Otherwise the next state is TRAILER or GAP.
//  BURST: src_ack[g] = tx_ready & src_valid[g]. This is combinational, from the state register and the inputs.
//   On ack: tx_write<=1, tx_data<=src_data[g], cnt<=cnt-1.
//   If ack occurs with cnt==1, exit to TRAILER or GAP.
//  tx_write<=0 on every cycle with no transfer. Stalls caused by tx_ready=0 or src_valid=0 may last any length.
//  src_req dropping mid-burst is ignored: the burst always completes exactly cnt words.
//   Changes to src_len after the grant are ignored.
//  GAP: src_grant=0 for GAP_CYC cycles. On entry, ptr<=(g+1) mod NUM_SRC.
//   Then IDLE: a source just served has the lowest priority next time.
//  Only one src_ack bit can be high in a cycle, and only for the granted source. tx_write never fires while tx_ready=0.
//  Throughput: 1 word/cycle while tx_ready & src_valid stay high.
//   Frame overhead = 1 header + (trailer) + GAP_CYC + 1 arbitration cycle.
//  src_len=0: header only, no src_ack.
// CONFIGURATION
//  TX_ARB_CHECKSUM_EN defined:
//   The TRAILER state appends one word = XOR of the header and all payload words of the burst.
//   That word is written when tx_ready=1, then the FSM goes to GAP. The checksum accumulator clears in IDLE.
//  TX_ARB_CHECKSUM_EN undefined:
//   No TRAILER state, and no accumulator logic. The FSM goes BURST/HEADER -> GAP.
// TESTING
//  1. Reset, src_req=4'b0001, len0=3, src_valid[0]=1, tx_ready=1.
//     -> Expect tx_data A5000003, d0, d1, d2 on consecutive cycles, and 3 src_ack[0] pulses.
//  2. src_req=4'b1111, all len=2.
//     -> Grant order is 0,1,2,3,0. Each header shows the correct source id.
//     -> No overlap between grants, and GAP_CYC idle cycles between frames.
//  3. Mid-burst, tx_ready=0 for 5 cycles, then src_valid=0 for 3 cycles.
//     -> No tx_write and no src_ack during the stalls. The word sequence is intact, with no duplicates.
//  4. len=0 on source 2.
//     -> Header A5020000 only. Then the trailer A5020000 if the macro is defined. No src_ack.
//  5. Assert rst_in after the 2nd payload word of a len=8 burst.
//     -> All outputs 0 in the same cycle. After release, the next request from source 0 is served first (ptr=0).
//  6. With TX_ARB_CHECKSUM_EN, burst {1,2,4} from source 1.
//     -> Header A5010003 is followed by 1,2,4, then trailer A5010003^7 = A5010004.

Source files
------------

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: round-robin arbiter that frames one burst per grant onto the FT245 tx path.
// Define TX_ARB_CHECKSUM_EN to append an XOR checksum trailer word to every frame.
module tx_stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int LEN_W   = 16,
  parameter int GAP_CYC = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*LEN_W-1:0] src_len,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*32-1:0]    src_data,
  output logic [NUM_SRC-1:0]       src_ack,
  output logic [NUM_SRC-1:0]       src_grant,
  input  logic                     tx_ready,
  output logic                     tx_write,
  output logic [31:0]              tx_data,
  output logic                     busy
);
  localparam int GW = $clog2(NUM_SRC);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd4;
`ifdef TX_ARB_CHECKSUM_EN
  localparam logic [2:0] S_TRL   = 3'd3;
  localparam logic [2:0] S_END   = S_TRL;
`else
  localparam logic [2:0] S_END   = S_GAP;
`endif
  logic [2:0]       state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d, g_q, g_d, win, idx;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             tx_write_q, tx_write_d, found, ack;
  logic [31:0]      tx_data_q, tx_data_d, hdr, word;
  logic [NUM_SRC-1:0] onehot;
  assign hdr       = {8'hA5, 4'h0, 4'(g_q), 16'(cnt_q)};
  assign word      = src_data[32*g_q +: 32];
  assign ack       = (state_q == S_BURST) & tx_ready & src_valid[g_q];
  assign onehot    = NUM_SRC'(1) << g_q;
  assign src_ack   = ack ? onehot : '0;
  assign src_grant = (state_q != S_IDLE && state_q != S_GAP) ? onehot : '0;
  assign busy      = state_q != S_IDLE;
  assign tx_write  = tx_write_q;
  assign tx_data   = tx_data_q;
  // smallest offset from ptr wins, so iterate from the far end down
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr_q) + k) % NUM_SRC);
      if (src_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
`ifdef TX_ARB_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
  assign acc_d = (state_q == S_IDLE) ? '0 :
                 (state_q == S_HDR && tx_ready) ? hdr :
                 ack ? (acc_q ^ word) : acc_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) acc_q <= '0;
    else        acc_q <= acc_d;
`endif
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: if (found) begin
        state_d = S_HDR;
        g_d     = win;
        cnt_d   = src_len[win*LEN_W +: LEN_W];
      end
      S_HDR: if (tx_ready) begin
        tx_write_d = 1'b1;
        tx_data_d  = hdr;
        state_d    = (cnt_q != '0) ? S_BURST : S_END;
      end
      S_BURST: if (ack) begin
        tx_write_d = 1'b1;
        tx_data_d  = word;
        cnt_d      = cnt_q - 1'b1;
        state_d    = (cnt_q == LEN_W'(1)) ? S_END : S_BURST;
      end
`ifdef TX_ARB_CHECKSUM_EN
      S_TRL: if (tx_ready) begin
        tx_write_d = 1'b1;
        tx_data_d  = acc_q;
        state_d    = S_GAP;
      end
`endif
      S_GAP: begin
        gap_d   = gap_q - 1'b1;
        state_d = (gap_q == 4'd0) ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_GAP && state_q != S_GAP) begin
      ptr_d = (g_q == GW'(NUM_SRC - 1)) ? '0 : g_q + 1'b1;
      gap_d = 4'(GAP_CYC - 1);
    end
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      g_q        <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
    end
endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb_tx_stream_arbiter: randomized frame-level reference model plus directed literal checks.
module tb_tx_stream_arbiter;
  localparam int N   = 4;
  localparam int LW  = 16;
  localparam int GAP = 1;
`ifdef TX_ARB_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] src_req, src_valid, src_ack, src_grant;
  logic [N*LW-1:0] src_len;
  logic [N*32-1:0] src_data;
  logic tx_ready, tx_write, busy;
  logic [31:0] tx_data;
  int checks = 0, errors = 0;
  int seq [N];
  int mseq [N];
  logic [LW-1:0] len_cfg [N];
  logic [31:0] expq [$];
  logic [31:0] wlog [$];
  int m_ptr, low_cnt, cur, cur_len, frame_pos, frame_total;
  logic [N-1:0] prev_grant, req_drive;
  bit rand_req, rand_len;
  int ready_pct, valid_pct, max_len;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_src
    assign src_data[i*32 +: 32] = {4'hD, 4'(i), 24'(seq[i])};
    assign src_len[i*LW +: LW]  = len_cfg[i];
  end

  tx_stream_arbiter #(.NUM_SRC(N), .LEN_W(LW), .GAP_CYC(GAP)) dut (
    .clk_in(clk), .rst_in(rst), .src_req(src_req), .src_len(src_len),
    .src_valid(src_valid), .src_data(src_data), .src_ack(src_ack),
    .src_grant(src_grant), .tx_ready(tx_ready), .tx_write(tx_write),
    .tx_data(tx_data), .busy(busy));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] wl(int i);
    return (i < wlog.size()) ? wlog[i] : 32'hxxxxxxxx;
  endfunction

  task automatic start_frame(int w, int len);
    logic [31:0] h, x;
    h = {8'hA5, 4'h0, 4'(w), 16'(len)};
    x = h;
    expq.push_back(h);
    for (int j = 0; j < len; j++) begin
      expq.push_back({4'hD, 4'(w), 24'(mseq[w])});
      x ^= {4'hD, 4'(w), 24'(mseq[w])};
      mseq[w]++;
    end
    if (CK != 0) expq.push_back(x);
    cur = w;
    cur_len = len;
    frame_pos = 0;
    frame_total = len + 1 + CK;
  endtask

  task automatic cycle();
    logic [N-1:0] req_v, valid_v, ack_v, exp_ack, exp_g;
    logic [LW-1:0] len_v [N];
    logic ready_v, exp_w;
    int w;
    src_req = rand_req ? N'($urandom) : req_drive;
    if (rand_len) for (int i = 0; i < N; i++) len_cfg[i] = LW'($urandom_range(0, max_len));
    for (int i = 0; i < N; i++) src_valid[i] = ($urandom_range(1, 100) <= valid_pct);
    tx_ready = ($urandom_range(1, 100) <= ready_pct);
    #2;
    req_v = src_req;
    valid_v = src_valid;
    ready_v = tx_ready;
    len_v = len_cfg;
    ack_v = src_ack;
    exp_ack = (prev_grant != 0 && frame_pos >= 1 && frame_pos <= cur_len && ready_v && valid_v[cur])
              ? N'(1) << cur : '0;
    chk("src_ack", src_ack, exp_ack);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ack_v[i]) seq[i]++;
    exp_w = prev_grant != 0 && ready_v && (frame_pos == 0 || frame_pos > cur_len || valid_v[cur]);
    chk("tx_write", tx_write, exp_w);
    if (tx_write) wlog.push_back(tx_data);
    if (tx_write && exp_w) chk("tx_data", tx_data, expq.size() ? expq.pop_front() : 32'hxxxxxxxx);
    if (exp_w) frame_pos++;
    exp_g = '0;
    if (prev_grant != 0) begin
      if (frame_pos == frame_total) begin
        m_ptr = (cur + 1) % N;
        low_cnt = 0;
      end else exp_g = prev_grant;
    end else begin
      low_cnt++;
      w = (low_cnt >= GAP + 1) ? rr(req_v, m_ptr) : -1;
      if (w >= 0) begin
        start_frame(w, int'(len_v[w]));
        exp_g = N'(1) << w;
      end
    end
    chk("src_grant", src_grant, exp_g);
    chk("busy", busy, exp_g != 0 || low_cnt < GAP);
    prev_grant = exp_g;
  endtask

  task automatic run(int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_write", tx_write, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant", src_grant, 0);
    chk("rst_ack", src_ack, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      mseq[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    wlog.delete();
    m_ptr = 0;
    low_cnt = GAP;
    prev_grant = '0;
    frame_pos = 0;
    frame_total = 0;
    cur = 0;
    cur_len = 0;
  endtask

  task automatic directed(logic [N-1:0] req, int tail);
    req_drive = req;
    run(1);
    req_drive = '0;
    run(tail);
  endtask

  initial begin
    logic [31:0] hdrs [$];
    rst = 1'b0;
    src_req = '0;
    src_valid = '0;
    tx_ready = 1'b0;
    req_drive = '0;
    rand_req = 0;
    rand_len = 0;
    ready_pct = 100;
    valid_pct = 100;
    max_len = 6;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      len_cfg[i] = '0;
    end
    #2;
    do_reset();
    len_cfg[0] = 3;
    directed(4'b0001, 10);
    chk("t1_hdr", wl(0), 32'hA500_0003);
    chk("t1_d0", wl(1), 32'hD000_0000);
    chk("t1_d1", wl(2), 32'hD000_0001);
    chk("t1_d2", wl(3), 32'hD000_0002);
    chk("t1_words", wlog.size(), 4 + CK);

    do_reset();
    for (int i = 0; i < N; i++) len_cfg[i] = 2;
    req_drive = 4'b1111;
    run(5 * (3 + CK + GAP + 1) - 1);
    req_drive = '0;
    run(10);
    foreach (wlog[i]) if (wlog[i][31:24] == 8'hA5) hdrs.push_back(wlog[i]);
    chk("t2_h0", hdrs.size() > 0 ? hdrs[0] : 'x, 32'hA500_0002);
    chk("t2_h1", hdrs.size() > 1 ? hdrs[1] : 'x, 32'hA501_0002);
    chk("t2_h2", hdrs.size() > 2 ? hdrs[2] : 'x, 32'hA502_0002);
    chk("t2_h3", hdrs.size() > 3 ? hdrs[3] : 'x, 32'hA503_0002);
    chk("t2_h4", hdrs.size() > 4 ? hdrs[4] : 'x, 32'hA500_0002);

    do_reset();
    len_cfg[0] = 8;
    directed(4'b0001, 3);
    ready_pct = 0;
    run(5);
    ready_pct = 100;
    valid_pct = 0;
    run(3);
    valid_pct = 100;
    run(15);
    chk("t3_words", wlog.size(), 9 + CK);
    chk("t3_last", wl(8), 32'hD000_0007);

    do_reset();
    len_cfg[2] = 0;
    directed(4'b0100, 6);
    chk("t4_hdr", wl(0), 32'hA502_0000);
    chk("t4_words", wlog.size(), 1 + CK);
    if (CK != 0) chk("t4_trl", wl(1), 32'hA502_0000);

    do_reset();
    len_cfg[0] = 8;
    len_cfg[1] = 1;
    len_cfg[3] = 1;
    directed(4'b0001, 3);
    chk("t5_pre", wlog.size(), 3);
    do_reset();
    directed(4'b1011, 20);
    chk("t5_hdr", wl(0), 32'hA500_0008);
    chk("t5_d0", wl(1), 32'hD000_0000);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      rand_req = 1;
      rand_len = 1;
      ready_pct = 75;
      valid_pct = 75;
      run(500);
    end
    rand_req = 0;
    rand_len = 0;
    req_drive = '0;
    ready_pct = 100;
    valid_pct = 100;
    run(30);
    chk("drain", expq.size(), 0);
    chk("drain_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
